// File: rtl/moving_average_normalizer.sv
// rtl/moving_average_normalizer.sv - serial restoring divider that turns a running sum into a saturated mean
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   integration_samples   divisor N, latched when a sum is accepted
//   sum_in, sum_in_valid  signed running sum and its one-cycle strobe
//   sum_in_ready          high while idle (combinational from state)
//   mean_out              signed mean, held between results
//   mean_out_valid        one-cycle pulse per result
//   mean_sat              result was clipped to the OUT_WIDTH range
//   dropped, drop_count   pulse and saturating count of strobes seen while busy
module moving_average_normalizer #(
    parameter int SUM_WIDTH = 32,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SUM_WIDTH-1:0] integration_samples,
    input  logic [SUM_WIDTH-1:0] sum_in,
    input  logic                 sum_in_valid,
    output logic                 sum_in_ready,
    output logic [OUT_WIDTH-1:0] mean_out,
    output logic                 mean_out_valid,
    output logic                 mean_sat,
    output logic                 dropped,
    output logic [15:0]          drop_count
);

    localparam int CW = $clog2(SUM_WIDTH + 1);
    // Magnitude limits of the output range, expressed in the quotient's width.
    localparam logic [SUM_WIDTH-1:0] LP_NEG_MAG = SUM_WIDTH'(1) << (OUT_WIDTH - 1);
    localparam logic [SUM_WIDTH-1:0] LP_POS_MAX = LP_NEG_MAG - SUM_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_FINISH
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                 r_sign;
    logic [SUM_WIDTH-1:0] r_mag;      // dividend in, quotient shifted in from the bottom
    logic [SUM_WIDTH-1:0] r_div;
    logic [SUM_WIDTH:0]   r_rem;
    logic [CW-1:0]        r_cnt;
    logic [OUT_WIDTH-1:0] r_mean;
    logic                 r_mean_valid;
    logic                 r_sat;
    logic                 r_dropped;
    logic [15:0]          r_drop_cnt;

    logic                 w_accept;
    logic                 w_busy_strobe;
    logic [SUM_WIDTH-1:0] w_abs;
    logic [SUM_WIDTH:0]   w_trial;
    logic                 w_ge;
    logic                 w_sat;
    logic [OUT_WIDTH-1:0] w_mag_out;
    logic [OUT_WIDTH-1:0] w_mean;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_busy_strobe = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sum_in_valid) begin
                    w_accept = 1'b1;
                    // N of 0 or 1 means no division: the magnitude is already the quotient.
                    if (integration_samples <= SUM_WIDTH'(1)) begin
                        w_state_next = S_FINISH;
                    end else begin
                        w_state_next = S_DIVIDE;
                    end
                end
            end
            S_DIVIDE: begin
                w_busy_strobe = sum_in_valid;
                if (r_cnt == CW'(1)) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_busy_strobe = sum_in_valid;
                w_state_next  = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // The most negative sum negates to itself, which read unsigned is exactly 2^(SUM_WIDTH-1).
    assign w_abs   = sum_in[SUM_WIDTH-1] ? -sum_in : sum_in;
    assign w_trial = (r_rem << 1) | {{SUM_WIDTH{1'b0}}, r_mag[SUM_WIDTH-1]};
    assign w_ge    = (w_trial >= {1'b0, r_div});

    // Saturate on the magnitude so the negative limit gets its one extra count.
    assign w_sat     = r_sign ? (r_mag > LP_NEG_MAG) : (r_mag > LP_POS_MAX);
    assign w_mag_out = r_mag[OUT_WIDTH-1:0];

    always_comb begin
        w_mean = r_sign ? -w_mag_out : w_mag_out;
        if (w_sat) begin
            w_mean = r_sign ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign       <= 1'b0;
            r_mag        <= '0;
            r_div        <= '0;
            r_rem        <= '0;
            r_cnt        <= '0;
            r_mean       <= '0;
            r_mean_valid <= 1'b0;
            r_sat        <= 1'b0;
            r_dropped    <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_sign <= sum_in[SUM_WIDTH-1];
                r_mag  <= w_abs;
                r_div  <= integration_samples;
                r_rem  <= '0;
                r_cnt  <= CW'(SUM_WIDTH);
            end else if (r_state == S_DIVIDE) begin
                r_rem <= w_ge ? (w_trial - {1'b0, r_div}) : w_trial;
                r_mag <= {r_mag[SUM_WIDTH-2:0], w_ge};
                r_cnt <= r_cnt - CW'(1);
            end

            r_mean_valid <= (r_state == S_FINISH);
            if (r_state == S_FINISH) begin
                r_mean <= w_mean;
                r_sat  <= w_sat;
            end

            r_dropped <= w_busy_strobe;
            if (w_busy_strobe && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign sum_in_ready   = (r_state == S_IDLE);
    assign mean_out       = r_mean;
    assign mean_out_valid = r_mean_valid;
    assign mean_sat       = r_sat;
    assign dropped        = r_dropped;
    assign drop_count     = r_drop_cnt;

endmodule

// File: tb/tb_moving_average_normalizer.sv
// tb/tb_moving_average_normalizer.sv - directed self-checking bench for moving_average_normalizer
module tb_moving_average_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] integration_samples;
    logic [31:0] sum_in;
    logic        sum_in_valid;
    logic        sum_in_ready;
    logic [15:0] mean_out;
    logic        mean_out_valid;
    logic        mean_sat;
    logic        dropped;
    logic [15:0] drop_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    moving_average_normalizer #(
        .SUM_WIDTH(32),
        .OUT_WIDTH(16)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .integration_samples (integration_samples),
        .sum_in              (sum_in),
        .sum_in_valid        (sum_in_valid),
        .sum_in_ready        (sum_in_ready),
        .mean_out            (mean_out),
        .mean_out_valid      (mean_out_valid),
        .mean_sat            (mean_sat),
        .dropped             (dropped),
        .drop_count          (drop_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the following posedge accepts the strobe.
    task automatic send(input logic [31:0] n, input logic [31:0] s);
        integration_samples = n;
        sum_in              = s;
        sum_in_valid        = 1'b1;
        @(negedge clk);
        sum_in_valid        = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output bit rdy_low);
        lat     = 0;
        rdy_low = 1'b1;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (mean_out_valid) break;
            if (sum_in_ready) rdy_low = 1'b0;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] n, input logic [31:0] s,
                       input logic [15:0] exp_mean, input logic exp_sat, input int exp_lat);
        int lat;
        bit rdy_low;
        send(n, s);
        wait_valid(lat, rdy_low);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_ready_low"}, {31'd0, rdy_low}, 32'd1);
        chk({tag, "_mean"}, {16'd0, mean_out}, {16'd0, exp_mean});
        chk({tag, "_sat"}, {31'd0, mean_sat}, {31'd0, exp_sat});
        @(negedge clk);
        chk({tag, "_pulse_end"}, {31'd0, mean_out_valid}, 32'd0);
        chk({tag, "_hold"}, {16'd0, mean_out}, {16'd0, exp_mean});
    endtask

    initial begin
        int  lat;
        bit  rdy_low;
        bit  seen;

        rst                 = 1'b1;
        sum_in_valid        = 1'b0;
        integration_samples = 32'd0;
        sum_in              = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_mean", {16'd0, mean_out}, 32'd0);
        chk("rst_valid", {31'd0, mean_out_valid}, 32'd0);
        chk("rst_sat", {31'd0, mean_sat}, 32'd0);
        chk("rst_dropped", {31'd0, dropped}, 32'd0);
        chk("rst_drop_count", {16'd0, drop_count}, 32'd0);
        chk("rst_ready", {31'd0, sum_in_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        run("n4_1000", 32'd4, 32'd1000, 16'd250, 1'b0, 33);
        run("n3_m10", 32'd3, 32'hFFFF_FFF6, 16'hFFFD, 1'b0, 33);
        run("n3_p10", 32'd3, 32'd10, 16'd3, 1'b0, 33);
        run("n7_minint", 32'd7, 32'h8000_0000, 16'h8000, 1'b1, 33);
        run("n0_pass", 32'd0, 32'd123, 16'd123, 1'b0, 1);
        run("n1_sat", 32'd1, 32'd100000, 16'h7FFF, 1'b1, 1);

        // Busy strobe 10 cycles after accept, with N changed at the same cycle.
        send(32'd5, 32'd500);
        repeat (9) @(negedge clk);
        integration_samples = 32'd2;
        sum_in              = 32'd999;
        sum_in_valid        = 1'b1;
        @(negedge clk);
        sum_in_valid        = 1'b0;
        chk("drop_pulse", {31'd0, dropped}, 32'd1);
        chk("drop_count_1", {16'd0, drop_count}, 32'd1);
        @(negedge clk);
        chk("drop_pulse_end", {31'd0, dropped}, 32'd0);
        wait_valid(lat, rdy_low);
        chk("drop_latency", lat, 32'd22);
        chk("drop_mean", {16'd0, mean_out}, 32'd100);
        chk("drop_count_hold", {16'd0, drop_count}, 32'd1);
        @(negedge clk);
        run("n2_after_drop", 32'd2, 32'd500, 16'd250, 1'b0, 33);

        // Reset 12 cycles into a division.
        send(32'd4, 32'd1000);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_mean", {16'd0, mean_out}, 32'd0);
        chk("midrst_valid", {31'd0, mean_out_valid}, 32'd0);
        chk("midrst_sat", {31'd0, mean_sat}, 32'd0);
        chk("midrst_dropped", {31'd0, dropped}, 32'd0);
        chk("midrst_drop_count", {16'd0, drop_count}, 32'd0);
        chk("midrst_ready", {31'd0, sum_in_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (mean_out_valid) seen = 1'b1;
        end
        chk("midrst_no_output", {31'd0, seen}, 32'd0);
        run("n8_64", 32'd8, 32'd64, 16'd8, 1'b0, 33);

        // Held strobe: one accept then 33 drops per 34-cycle round.
        integration_samples = 32'd4;
        sum_in              = 32'd1000;
        sum_in_valid        = 1'b1;
        repeat (34) @(negedge clk);
        chk("sat_drop_33", {16'd0, drop_count}, 32'd33);
        repeat (72166) @(negedge clk);
        chk("sat_drop_max", {16'd0, drop_count}, 32'h0000_FFFF);
        repeat (34) @(negedge clk);
        chk("sat_drop_nowrap", {16'd0, drop_count}, 32'h0000_FFFF);
        sum_in_valid = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
